// File: rtl/rx_pkg.sv
// Shared constants, sample-point encoding and small helpers for the
// UART receive bit-timing front end.
package rx_pkg;

  localparam int PRESCALE_W     = 6;
  localparam int EDGE_W         = 5;
  localparam int BIT_W          = 4;
  localparam int DATA_BITS      = 8;
  localparam int START_IDX      = 0;
  localparam int FIRST_DATA_IDX = 1;

  // Position of the current cycle relative to the three mid-bit sample points.
  typedef enum logic [1:0] {
    SP_NONE   = 2'd0,
    SP_FIRST  = 2'd1,
    SP_SECOND = 2'd2,
    SP_VOTE   = 2'd3
  } sample_pt_e;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic logic [BIT_W-1:0] frame_len(input logic par_en);
    logic [BIT_W-1:0] len;
    len = BIT_W'(DATA_BITS + 2);
    if (par_en) begin
      len = len + BIT_W'(1);
    end else begin
      len = len;
    end
    return len;
  endfunction

  // Two-out-of-three majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Edge (cycle-within-bit) and bit (bit-within-frame) counters for the
// receiver. Both clear whenever enable is low and wrap at the end of a
// bit / frame so back-to-back frames need no gap.
module rx_edge_bit_counter
  import rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt
);

  localparam int EXT_W = PRESCALE_W + 1;

  logic [EXT_W-1:0]  prescale_ext_s;
  logic [EXT_W-1:0]  last_edge_ext_s;
  logic [EDGE_W-1:0] last_edge_s;
  logic [BIT_W-1:0]  last_bit_s;

  // Terminal counts: last cycle of a bit and last bit of a frame.
  always_comb begin
    prescale_ext_s  = {1'b0, prescale};
    last_edge_ext_s = prescale_ext_s - EXT_W'(1);
    last_edge_s     = EDGE_W'(last_edge_ext_s);
    last_bit_s      = frame_len(par_en) - BIT_W'(1);
  end

  // Counter state: clear when idle, otherwise count cycles and bits with wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= EDGE_W'(0);
      bit_cnt  <= BIT_W'(START_IDX);
    end else if (!enable) begin
      edge_cnt <= EDGE_W'(0);
      bit_cnt  <= BIT_W'(START_IDX);
    end else if (edge_cnt == last_edge_s) begin
      edge_cnt <= EDGE_W'(0);
      if (bit_cnt == last_bit_s) begin
        bit_cnt <= BIT_W'(START_IDX);
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end else begin
      edge_cnt <= edge_cnt + EDGE_W'(1);
      bit_cnt  <= bit_cnt;
    end
  end

endmodule

// File: rtl/rx_bit_timing.sv
// UART receive bit-timing front end: per-bit edge/bit counters plus a
// three-point majority-vote sampler centred on mid-bit.
module rx_bit_timing
  import rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  enable,
  input  logic                  dat_samp_en,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  localparam int EXT_W = PRESCALE_W + 1;

  logic [EXT_W-1:0] prescale_ext_s;
  logic [EXT_W-1:0] half_s;
  logic [EXT_W-1:0] edge_ext_s;
  sample_pt_e       sample_pt_s;
  logic             run_s;

  logic             s0_r;
  logic             s1_r;
  logic             got0_r;
  logic             got1_r;

  rx_edge_bit_counter u_counter (
    .clk      (CLK),
    .rst      (RESET),
    .enable   (enable),
    .par_en   (PAR_EN),
    .prescale (Prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  // Decode which of the mid-bit sample points (H-2, H-1, H) this cycle is.
  always_comb begin
    prescale_ext_s = {1'b0, Prescale};
    half_s         = prescale_ext_s >> 1;
    edge_ext_s     = EXT_W'(edge_cnt);
    run_s          = enable & dat_samp_en;
    sample_pt_s    = SP_NONE;
    if (edge_ext_s == (half_s - EXT_W'(2))) begin
      sample_pt_s = SP_FIRST;
    end else if (edge_ext_s == (half_s - EXT_W'(1))) begin
      sample_pt_s = SP_SECOND;
    end else if (edge_ext_s == half_s) begin
      sample_pt_s = SP_VOTE;
    end else begin
      sample_pt_s = SP_NONE;
    end
  end

  // Capture the first two samples, then vote with the live third one.
  // The got flags make sure a vote only uses samples from an unbroken run;
  // any gap in the sampler enable discards the partial vote.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s0_r         <= 1'b1;
      s1_r         <= 1'b1;
      got0_r       <= 1'b0;
      got1_r       <= 1'b0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else if (!run_s) begin
      got0_r       <= 1'b0;
      got1_r       <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (sample_pt_s)
        SP_FIRST: begin
          s0_r   <= RX_IN;
          got0_r <= 1'b1;
          got1_r <= 1'b0;
        end
        SP_SECOND: begin
          s1_r   <= RX_IN;
          got1_r <= got0_r;
        end
        SP_VOTE: begin
          if (got1_r) begin
            sampled_bit  <= maj3(s0_r, s1_r, RX_IN);
            sample_valid <= 1'b1;
          end else begin
            sampled_bit  <= sampled_bit;
            sample_valid <= 1'b0;
          end
          got0_r <= 1'b0;
          got1_r <= 1'b0;
        end
        default: begin
          s0_r <= s0_r;
          s1_r <= s1_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bit_timing.sv
// Self-checking bench for rx_bit_timing: scenario tasks drive bit streams,
// expected votes go into a scoreboard queue, a negedge monitor pops them.
module tb_rx_bit_timing;
  import rx_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  enable;
  logic                  dat_samp_en;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;

  typedef struct {
    logic val;
    int   edge_at;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   obs_edge[$];
  int   obs_bit[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_pulse = 0;

  rx_bit_timing dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .enable       (enable),
    .dat_samp_en  (dat_samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  always #5 CLK = ~CLK;

  // Scoreboard monitor: every sample_valid pulse must match the next expected vote.
  always @(negedge CLK) begin
    if (!RESET && sample_valid) begin
      n_pulse++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got sample_valid=1 at edge_cnt=%0d bit_cnt=%0d, required no pulse",
                 edge_cnt, bit_cnt);
      end else begin
        mon_e = sb_q.pop_front();
        if (sampled_bit !== mon_e.val || int'(edge_cnt) !== mon_e.edge_at) begin
          n_err++;
          $display("FAIL sample: got bit=%0b at edge_cnt=%0d, required bit=%0b at edge_cnt=%0d",
                   sampled_bit, edge_cnt, mon_e.val, mon_e.edge_at);
        end
      end
    end
  end

  task automatic drive_bit(input logic val, input int presc, input int ncyc,
                           input logic [31:0] glitch, input logic [31:0] samp_off,
                           input bit push, input logic exp_val);
    exp_t e;
    if (push) begin
      e.val     = exp_val;
      e.edge_at = presc / 2 + 1;
      sb_q.push_back(e);
    end
    for (int c = 0; c < ncyc; c++) begin
      RX_IN       = val ^ glitch[c];
      dat_samp_en = ~samp_off[c];
      obs_edge.push_back(int'(edge_cnt));
      obs_bit.push_back(int'(bit_cnt));
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    enable      = 1'b0;
    dat_samp_en = 1'b0;
    RX_IN       = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_run(input int presc, input logic par);
    Prescale = PRESCALE_W'(presc);
    PAR_EN   = par;
    obs_edge.delete();
    obs_bit.delete();
    n_pulse  = 0;
    enable      = 1'b1;
    dat_samp_en = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; RX_IN = 1'b1; enable = 1'b0; dat_samp_en = 1'b0;
    Prescale = PRESCALE_W'(8); PAR_EN = 1'b0;
    #2;
    n_cmp++;
    if (edge_cnt !== 5'd0 || bit_cnt !== 4'd0 || sampled_bit !== 1'b1 || sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got %0d/%0d/%0b/%0b, required 0/0/1/0",
               edge_cnt, bit_cnt, sampled_bit, sample_valid);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle(2);
  endtask

  task automatic test_frame_0x55();
    logic [10:0] bits;
    bits[0] = 1'b0; bits[8:1] = 8'h55; bits[9] = 1'b1; bits[10] = 1'b1;
    start_run(8, 1'b0);
    for (int b = 0; b < 11; b++) drive_bit(bits[b], 8, 8, 32'h0, 32'h0, 1'b1, bits[b]);
    for (int i = 0; i < 88; i++) begin
      n_cmp++;
      if (obs_edge[i] !== i % 8 || obs_bit[i] !== (i / 8) % 10) begin
        n_err++;
        $display("FAIL frame55_count[%0d]: got edge=%0d bit=%0d, required edge=%0d bit=%0d",
                 i, obs_edge[i], obs_bit[i], i % 8, (i / 8) % 10);
      end
    end
    n_cmp++;
    if (n_pulse !== 11 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL frame55_pulses: got %0d pulses, %0d pending, required 11 and 0", n_pulse, sb_q.size());
    end
    idle(1);
    n_cmp++;
    if (edge_cnt !== 5'd0 || bit_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL frame55_disable: got %0d/%0d, required 0/0", edge_cnt, bit_cnt);
    end
    idle(2);
  endtask

  task automatic test_glitch();
    logic [31:0] g1;
    logic [31:0] g2;
    g1 = 32'h0000_0080;
    g2 = 32'h0000_0180;
    start_run(16, 1'b0);
    drive_bit(1'b0, 16, 16, 32'h0, 32'h0, 1'b1, 1'b0);
    drive_bit(1'b0, 16, 16, g1, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (sampled_bit !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_1cycle: got sampled_bit=%0b, required 0", sampled_bit);
    end
    idle(2);
    start_run(16, 1'b0);
    drive_bit(1'b0, 16, 16, 32'h0, 32'h0, 1'b1, 1'b0);
    drive_bit(1'b0, 16, 16, g2, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (sampled_bit !== 1'b1 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL glitch_2cycle: got sampled_bit=%0b pending=%0d, required 1 and 0", sampled_bit, sb_q.size());
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [21:0] bits;
    logic [7:0]  d0;
    logic [7:0]  d1;
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    bits = {1'b1, ^d1, d1, 1'b0, 1'b1, ^d0, d0, 1'b0};
    start_run(32, 1'b1);
    for (int b = 0; b < 22; b++) drive_bit(bits[b], 32, 32, 32'h0, 32'h0, 1'b1, bits[b]);
    for (int i = 0; i < 704; i++) begin
      n_cmp++;
      if (obs_edge[i] !== i % 32 || obs_bit[i] !== (i / 32) % 11) begin
        n_err++;
        $display("FAIL b2b_count[%0d]: got edge=%0d bit=%0d, required edge=%0d bit=%0d",
                 i, obs_edge[i], obs_bit[i], i % 32, (i / 32) % 11);
      end
    end
    n_cmp++;
    if (n_pulse !== 22 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d pulses, %0d pending, required 22 and 0", n_pulse, sb_q.size());
    end
    idle(2);
  endtask

  task automatic test_enable_drop();
    start_run(8, 1'b0);
    drive_bit(1'b0, 8, 8, 32'h0, 32'h0, 1'b1, 1'b0);
    drive_bit(1'b1, 8, 8, 32'h0, 32'h0, 1'b1, 1'b1);
    drive_bit(1'b1, 8, 8, 32'h0, 32'h0, 1'b1, 1'b1);
    drive_bit(1'b0, 8, 4, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) begin
      n_cmp++;
      if (obs_edge[i] !== i % 8 || obs_bit[i] !== i / 8) begin
        n_err++;
        $display("FAIL drop_count[%0d]: got edge=%0d bit=%0d, required edge=%0d bit=%0d",
                 i, obs_edge[i], obs_bit[i], i % 8, i / 8);
      end
    end
    enable = 1'b0;
    @(posedge CLK); #1;
    n_cmp++;
    if (edge_cnt !== 5'd0 || bit_cnt !== 4'd0 || sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_clear: got %0d/%0d valid=%0b, required 0/0 valid=0", edge_cnt, bit_cnt, sample_valid);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (n_pulse !== 3 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL drop_pulses: got %0d pulses, %0d pending, required 3 and 0", n_pulse, sb_q.size());
    end
    obs_edge.delete();
    obs_bit.delete();
    enable = 1'b1;
    drive_bit(1'b0, 8, 8, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs_edge[i] !== i || obs_bit[i] !== 0) begin
        n_err++;
        $display("FAIL reenable_count[%0d]: got edge=%0d bit=%0d, required edge=%0d bit=0",
                 i, obs_edge[i], obs_bit[i], i);
      end
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    logic [5:0] bits;
    bits = 6'b011010;
    start_run(8, 1'b0);
    for (int b = 0; b < 5; b++) drive_bit(bits[b], 8, 8, 32'h0, 32'h0, 1'b1, bits[b]);
    drive_bit(bits[5], 8, 6, 32'h0, 32'h0, 1'b1, bits[5]);
    n_cmp++;
    if (edge_cnt !== 5'd6 || bit_cnt !== 4'd5 || sampled_bit !== 1'b0) begin
      n_err++;
      $display("FAIL pre_reset: got %0d/%0d bit=%0b, required 6/5 bit=0", edge_cnt, bit_cnt, sampled_bit);
    end
    #3;
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (edge_cnt !== 5'd0 || bit_cnt !== 4'd0 || sampled_bit !== 1'b1 || sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got %0d/%0d/%0b/%0b, required 0/0/1/0",
               edge_cnt, bit_cnt, sampled_bit, sample_valid);
    end
    @(posedge CLK); #1;
    RX_IN = 1'b1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    n_cmp++;
    if (edge_cnt !== 5'd1 || bit_cnt !== 4'd0 || sampled_bit !== 1'b1 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL reset_release: got %0d/%0d bit=%0b pending=%0d, required 1/0 bit=1 pending=0",
               edge_cnt, bit_cnt, sampled_bit, sb_q.size());
    end
    idle(2);
  endtask

  task automatic test_samp_en_low();
    start_run(8, 1'b0);
    drive_bit(1'b0, 8, 8, 32'h0, 32'h0, 1'b1, 1'b0);
    drive_bit(1'b1, 8, 8, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    n_cmp++;
    if (sampled_bit !== 1'b0 || n_pulse !== 1) begin
      n_err++;
      $display("FAIL samp_off_bit: got bit=%0b pulses=%0d, required bit=0 pulses=1", sampled_bit, n_pulse);
    end
    drive_bit(1'b1, 8, 8, 32'h0, 32'h0000_0008, 1'b0, 1'b0);
    n_cmp++;
    if (sampled_bit !== 1'b0 || n_pulse !== 1) begin
      n_err++;
      $display("FAIL partial_vote: got bit=%0b pulses=%0d, required bit=0 pulses=1", sampled_bit, n_pulse);
    end
    drive_bit(1'b1, 8, 8, 32'h0, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (sampled_bit !== 1'b1 || n_pulse !== 2 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL samp_resume: got bit=%0b pulses=%0d pending=%0d, required 1/2/0",
               sampled_bit, n_pulse, sb_q.size());
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_frame_0x55();
    test_glitch();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    test_samp_en_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
